// File: rtl/rotate_pkg.sv
// -----------------------------------------------------------------------------
// rotate_pkg
// Shared constants and types for the rotating-square pattern generator.
//   SEG_*      : active-low segment patterns, bit order {dp,g,f,e,d,c,b,a}
//   MODE_*     : encoding of the mode input / registered mode
//   dir_t      : bounce direction (DIR_UP = position increments)
//   pos_width  : width of the position register for a given digit count
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package rotate_pkg;

  localparam logic [7:0] SEG_UPPER = 8'h9C;  // a,b,f,g lit
  localparam logic [7:0] SEG_LOWER = 8'hA3;  // c,d,e,g lit
  localparam logic [7:0] SEG_BLANK = 8'hFF;  // all off

  localparam logic MODE_ROTATE = 1'b0;
  localparam logic MODE_BOUNCE = 1'b1;

  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } dir_t;

  // Positions run 0..2*digits-1 (upper squares, then lower squares).
  function automatic int pos_width(input int digits);
    return $clog2(2 * digits);
  endfunction

endpackage

// File: rtl/rotate_tick_gen.sv
// -----------------------------------------------------------------------------
// rotate_tick_gen
// Step prescaler. Counts 0..(TICK_DIV>>speed)-1 while enabled and emits a
// combinational one-cycle tick on the final count.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   en     in   1 = count, 0 = hold count (tick forced low)
//   speed  in   step period = TICK_DIV >> speed clocks
//   tick   out  one-cycle pulse, high while en && count reached limit-1
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module rotate_tick_gen #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] speed,
  output logic       tick
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic [CW-1:0] limit_m1;

  // TICK_DIV >= 8 guarantees the shifted limit is at least 1.
  always_comb limit_m1 = CW'((TICK_DIV >> speed) - 1);

  // ">=" rather than "==": if speed shortens the period while the count is
  // already past the new terminal value, fire right away and restart.
  assign tick = en && (cnt_reg >= limit_m1);

  always_comb begin
    cnt_next = cnt_reg;
    if (en) begin
      cnt_next = tick ? '0 : cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/rotate_sq_gen.sv
// -----------------------------------------------------------------------------
// rotate_sq_gen
// Rotating-square pattern generator for a DIGITS-wide seven-segment display.
// Positions 0..DIGITS-1 place an upper square moving left to right, positions
// DIGITS..2*DIGITS-1 a lower square moving right to left. Rotate mode wraps,
// bounce mode ping-pongs between the two ends.
//
// Build option: define ROTATE_STEP_EN to add the `step` input, which single-
// steps the pattern on its rising edge while en=0.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   en       in   1 = run, 0 = freeze
//   cw       in   rotate direction, 1 = position increments
//   mode     in   0 = rotate (wrap), 1 = bounce
//   speed    in   step period = TICK_DIV >> speed clocks
//   step     in   single-step pulse (ROTATE_STEP_EN only)
//   seg_bus  out  active-low segments, digit i on [8i+7:8i]
//   pos      out  current square position
//   tick     out  one-cycle pulse on each step
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module rotate_sq_gen
  import rotate_pkg::*;
#(
  parameter int DIGITS   = 6,
  parameter int TICK_DIV = 25_000_000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic                           cw,
  input  logic                           mode,
  input  logic [1:0]                     speed,
`ifdef ROTATE_STEP_EN
  input  logic                           step,
`endif
  output logic [8*DIGITS-1:0]            seg_bus,
  output logic [pos_width(DIGITS)-1:0]   pos,
  output logic                           tick
);

  localparam int PW = pos_width(DIGITS);
  localparam int P  = 2 * DIGITS;
  localparam logic [PW-1:0] POS_LAST = PW'(P - 1);
  localparam logic [PW-1:0] POS_PREV = PW'(P - 2);

  logic          gen_tick;
  logic [PW-1:0] pos_reg;
  logic [PW-1:0] pos_next;
  dir_t          dir_reg;
  dir_t          dir_next;
  logic          mode_q_reg;
  logic          mode_entry;

  rotate_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .speed (speed),
    .tick  (gen_tick)
  );

`ifdef ROTATE_STEP_EN
  // Manual stepping: rising edge of step while frozen produces a registered
  // tick one cycle later, which then drives the normal step update.
  logic step_q_reg;
  logic step_tick_reg;
  logic step_rise;

  assign step_rise = step && !step_q_reg && !en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q_reg    <= 1'b0;
      step_tick_reg <= 1'b0;
    end else begin
      step_q_reg    <= step;
      step_tick_reg <= step_rise;
    end
  end

  assign tick = gen_tick || step_tick_reg;
`else
  assign tick = gen_tick;
`endif

  // mode_q is registered unconditionally so mode changes land even when frozen.
  assign mode_entry = (mode == MODE_BOUNCE) && (mode_q_reg == MODE_ROTATE);

  always_comb begin
    pos_next = pos_reg;
    dir_next = dir_reg;

    // Entering bounce: seed the direction from cw, keep the position.
    if (mode_entry) begin
      dir_next = cw ? DIR_UP : DIR_DN;
    end

    if (tick) begin
      if (mode_q_reg == MODE_ROTATE) begin
        if (cw) begin
          pos_next = (pos_reg == POS_LAST) ? '0 : pos_reg + PW'(1);
        end else begin
          pos_next = (pos_reg == '0) ? POS_LAST : pos_reg - PW'(1);
        end
      end else begin
        // Bounce: turning around also moves one step, so the end position
        // is shown for exactly one step period.
        if (dir_reg == DIR_UP) begin
          if (pos_reg == POS_LAST) begin
            dir_next = DIR_DN;
            pos_next = POS_PREV;
          end else begin
            pos_next = pos_reg + PW'(1);
          end
        end else begin
          if (pos_reg == '0) begin
            dir_next = DIR_UP;
            pos_next = PW'(1);
          end else begin
            pos_next = pos_reg - PW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_reg    <= '0;
      dir_reg    <= DIR_UP;
      mode_q_reg <= MODE_ROTATE;
    end else begin
      pos_reg    <= pos_next;
      dir_reg    <= dir_next;
      mode_q_reg <= mode;
    end
  end

  assign pos = pos_reg;

  // Each digit owns one upper and one lower position.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign seg_bus[8*gi +: 8] =
        (pos_reg == PW'(DIGITS - 1 - gi)) ? SEG_UPPER :
        (pos_reg == PW'(DIGITS + gi))     ? SEG_LOWER :
                                            SEG_BLANK;
    end
  endgenerate

endmodule

// File: tb/tb_rotate_sq_gen.sv
// -----------------------------------------------------------------------------
// tb_rotate_sq_gen
// Self-checking bench for rotate_sq_gen with DIGITS=6, TICK_DIV=5, 20 ns clock.
// Stimulus pushes the expected (tick interval, position) of every step into a
// queue; a monitor pops one entry per observed tick and compares interval,
// position and segment bus. Define ROTATE_STEP_EN to add the single-step test.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_rotate_sq_gen;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        cw;
  logic        mode;
  logic [1:0]  speed;
`ifdef ROTATE_STEP_EN
  logic        step;
`endif
  logic [47:0] seg_bus;
  logic [3:0]  pos;
  logic        tick;

  int n_pass  = 0;
  int n_total = 0;
  int since;

  typedef struct {
    int gap;
    int pos;
  } exp_t;

  exp_t exp_q[$];

  rotate_sq_gen #(
    .DIGITS   (6),
    .TICK_DIV (5)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .cw      (cw),
    .mode    (mode),
    .speed   (speed),
`ifdef ROTATE_STEP_EN
    .step    (step),
`endif
    .seg_bus (seg_bus),
    .pos     (pos),
    .tick    (tick)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Clocks elapsed up to a tick, counting from the previous tick or reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)    since <= 1;
    else if (tick) since <= 1;
    else           since <= since + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
  endtask

  // Expected display for a position: upper square on digit 5-p, lower on p-6.
  function automatic logic [47:0] exp_seg(input int p);
    logic [47:0] s;
    s = '1;
    if (p < 6) s[8*(5-p) +: 8] = 8'h9C;
    else       s[8*(p-6) +: 8] = 8'hA3;
    return s;
  endfunction

  // Monitor: one scoreboard entry per tick.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && tick === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_tick actual_pos=%0d required=no_tick at %0t", pos, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("tick pos=%0d gap=%0d seg=%h", pos, since, seg_bus);
        check("tick_gap", since, e.gap);
        check("tick_pos", pos, e.pos);
        check("tick_seg", seg_bus, exp_seg(e.pos));
      end
    end
  end

  task automatic push(input int gap, input int p);
    exp_t e;
    e.gap = gap;
    e.pos = p;
    exp_q.push_back(e);
  endtask

  // Rotate run at speed 0: count steps from first, moving by d (+1/-1).
  task automatic push_run(input int first, input int count, input int d);
    int p;
    p = first;
    for (int i = 0; i < count; i++) begin
      push(5, p);
      p = (p + d + 12) % 12;
    end
  endtask

  // Wait for the scoreboard to empty; returns 1 ns after the final step edge.
  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain_timeout actual_left=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq3[15] = '{9, 10, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1};

    rst_n = 1'b0;
    en    = 1'b1;
    cw    = 1'b1;
    mode  = 1'b0;
    speed = 2'd0;
`ifdef ROTATE_STEP_EN
    step  = 1'b0;
`endif

    // 1. Reset state, then clockwise rotation through all 12 positions.
    #5;
    check("reset_pos", pos, 0);
    check("reset_tick", tick, 0);
    check("reset_seg", seg_bus, 48'h9CFF_FFFF_FFFF);
    do_reset();
    push_run(0, 6, 1);
    drain();
    check("cw_pos6", pos, 6);
    check("cw_seg_pos6", seg_bus, 48'hFFFF_FFFF_FFA3);
    push_run(6, 7, 1);
    drain();
    check("cw_wrap_pos", pos, 1);
    check("cw_wrap_seg", seg_bus, 48'hFF9C_FFFF_FFFF);

    // 2. Counter-clockwise from reset: 0 -> 11 -> ... -> 0 -> 11.
    cw = 1'b0;
    do_reset();
    push_run(0, 13, -1);
    drain();
    check("ccw_pos11", pos, 11);
    check("ccw_seg_pos11", seg_bus, 48'hA3FF_FFFF_FFFF);

    // 3. Bounce entered at pos 9 with cw=1; cw dropped afterwards is ignored.
    cw = 1'b1;
    do_reset();
    push_run(0, 9, 1);
    drain();
    check("pre_bounce_pos", pos, 9);
    mode = 1'b1;
    foreach (seq3[i]) push(5, seq3[i]);
    @(posedge clk); #1;
    @(posedge clk); #1;
    cw = 1'b0;
    drain();
    check("bounce_end_pos", pos, 2);
    check("bounce_end_seg", seg_bus, 48'hFFFF_9CFF_FFFF);

    // 4. Speed 0 -> 2 while the count is 3: immediate tick, then every clock.
    mode = 1'b0;
    cw   = 1'b1;
    do_reset();
    push(5, 0);
    drain();
    push(4, 1);
    push(1, 2);
    push(1, 3);
    repeat (3) @(posedge clk);
    #1;
    speed = 2'd2;
    drain();
    en = 1'b0;
    check("speed_end_pos", pos, 4);

    // 5. Freeze at pos 4, then a 2 ns reset pulse while running.
    speed = 2'd0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("freeze_pos", pos, 4);
      check("freeze_tick", tick, 0);
    end
    @(posedge clk); #1;
    en = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #5;
    check("pre_pulse_pos", pos, 4);
    rst_n = 1'b0;
    push(5, 0);
    #1;
    check("pulse_pos", pos, 0);
    check("pulse_seg", seg_bus, 48'h9CFF_FFFF_FFFF);
    check("pulse_tick", tick, 0);
    #1;
    rst_n = 1'b1;
    drain();
    en = 1'b0;
    check("post_pulse_pos", pos, 1);

`ifdef ROTATE_STEP_EN
    // 6. Single stepping while frozen: three pulses 10 clocks apart.
    do_reset();
    push(3, 0);
    push(10, 1);
    push(10, 2);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      step = 1'b1;
      @(posedge clk); #1;
      step = 1'b0;
      repeat (8) @(posedge clk);
    end
    drain();
    check("step_end_pos", pos, 3);
    check("step_end_seg", seg_bus, 48'hFFFF_FF9C_FFFF);
`endif

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
